// File: rtl/conv_encoder_system.sv
// conv_encoder_system: rate-1/2 K=3 (7,5) convolutional encoder behind a byte FIFO; define TAIL_FLUSH_EN for tail flush
module conv_encoder_system #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dvalid_i,
  input  logic [7:0]  data_i,
  input  logic        flush_i,
  output logic [15:0] data_o,
  output logic        valid_o,
  output logic        busy_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic full, empty, wr, rd, pad, ld, last, pend, g0, g1;
  logic [2:0] cnt;
  logic [1:0] s;
  logic [7:0] sr;
  logic [13:0] w;
  assign busy_o = full;
  assign wr = dvalid_i & ~full;
  assign last = state == SHIFT && cnt == 3'd7;
  assign g0 = sr[7] ^ s[1] ^ s[0];
  assign g1 = sr[7] ^ s[0];
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb
    state_n = ld ? SHIFT : last ? IDLE : state;
  always_comb begin
    rd = (state == IDLE || last) && !empty;
    pad = (state == IDLE || last) && empty && pend;
    ld = rd | pad;
  end
`ifdef TAIL_FLUSH_EN
  always_ff @(posedge clk)
    pend <= rst ? 1'b0 : pad ? 1'b0 : pend | flush_i;
`else
  logic unused_flush;
  assign unused_flush = flush_i;
  assign pend = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (wr) begin
        mem[wp] <= data_i;
        wp <= wp + 1'b1;
      end
      if (rd) rp <= rp + 1'b1;
      if (wr && !rd) begin
        empty <= 1'b0;
        full <= wp + 1'b1 == rp;
      end else if (rd && !wr) begin
        full <= 1'b0;
        empty <= rp + 1'b1 == wp;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 3'd0;
      s <= 2'b00;
      sr <= 8'h00;
      w <= '0;
      data_o <= 16'h0000;
      valid_o <= 1'b0;
    end else begin
      valid_o <= last;
      if (state == SHIFT) begin
        s <= {sr[7], s[1]};
        sr <= {sr[6:0], 1'b0};
        w <= {w[11:0], g0, g1};
        cnt <= cnt + 1'b1;
      end
      if (last) data_o <= {w, g0, g1};
      if (ld) begin
        sr <= pad ? 8'h00 : mem[rp];
        cnt <= 3'd0;
      end
    end
  end
endmodule

// File: tb/tb_conv_encoder_system.sv
// tb_conv_encoder_system: scoreboard bench for conv_encoder_system
module tb_conv_encoder_system;
  logic clk = 0, rst = 1, dvalid_i = 0, flush_i = 0;
  logic [7:0] data_i = 0;
  logic [15:0] data_o;
  logic valid_o, busy_o;
  int tests = 0, fails = 0, cyc = 0, vcyc = 0, pvcyc = 0, nval = 0, t0 = 0, exp_n = 0;
  logic [15:0] q [$];
  logic [1:0] m_s = 2'b00;
  conv_encoder_system #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .dvalid_i(dvalid_i), .data_i(data_i), .flush_i(flush_i),
    .data_o(data_o), .valid_o(valid_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic logic [15:0] enc(input logic [7:0] b);
    logic [15:0] r;
    logic u;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      u = b[7-k];
      r[15-2*k] = u ^ m_s[1] ^ m_s[0];
      r[14-2*k] = u ^ m_s[0];
      m_s = {u, m_s[1]};
    end
    return r;
  endfunction
  task automatic push(input logic [7:0] b);
    q.push_back(enc(b));
  endtask
  task automatic do_reset;
    rst = 1;
    dvalid_i = 1;
    data_i = 8'hff;
    q.delete();
    m_s = 2'b00;
    repeat (2) @(negedge clk);
    rst = 0;
    dvalid_i = 0;
    nval = 0;
  endtask
  task automatic write(input logic [7:0] b);
    dvalid_i = 1;
    data_i = b;
    push(b);
    @(negedge clk);
    dvalid_i = 0;
    t0 = cyc;
  endtask
  task automatic pulse_flush;
    flush_i = 1;
    @(negedge clk);
    flush_i = 0;
  endtask
  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (12) @(negedge clk);
    check("drain", q.size(), 0);
  endtask
  always @(negedge clk)
    if (valid_o === 1'b1) begin
      pvcyc = vcyc;
      vcyc = cyc;
      nval++;
      if (q.size() == 0) check("spurious_valid", 1, 0);
      else check("word", data_o, q.pop_front());
    end
  initial begin
    @(negedge clk);
    do_reset;
    check("rst_data", data_o, 16'h0000);
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    write(8'h80);
    drain(30);
    check("lat_80", vcyc - t0, 9);
    check("n_80", nval, 1);
    check("d_80", data_o, 16'hec00);
    write(8'h80);
    drain(30);
    check("n_80b", nval, 2);
    do_reset;
    write(8'hff);
    write(8'h00);
    drain(40);
    check("gap_b2b", vcyc - pvcyc, 8);
    check("n_b2b", nval, 2);
    do_reset;
    write(8'hff);
    pulse_flush;
    @(negedge clk);
    pulse_flush;
`ifdef TAIL_FLUSH_EN
    push(8'h00);
    exp_n = 2;
`else
    exp_n = 1;
`endif
    drain(40);
    check("n_flush", nval, exp_n);
    write(8'h80);
    drain(30);
    check("n_flush_after", nval, exp_n + 1);
    do_reset;
    for (int i = 0; i < 20; i++) begin
      dvalid_i = 1;
      data_i = 8'($urandom);
      if (i <= 4 || i == 10 || i == 18) push(data_i);
      @(negedge clk);
      check($sformatf("busy_%0d", i), busy_o, (i >= 4 && i <= 8) || (i >= 10 && i <= 16) || i >= 18);
    end
    dvalid_i = 0;
    drain(100);
    check("n_burst", nval, 7);
    do_reset;
    write(8'h80);
    repeat (5) @(negedge clk);
    do_reset;
    check("mid_rst_data", data_o, 16'h0000);
    check("mid_rst_busy", busy_o, 0);
    repeat (15) @(negedge clk);
    check("mid_rst_nval", nval, 0);
    check("mid_rst_hold", data_o, 16'h0000);
    write(8'h80);
    drain(30);
    check("n_rewrite", nval, 1);
    check("d_rewrite", data_o, 16'hec00);
    do_reset;
    write(8'h00);
    drain(30);
    check("n_zero", nval, 1);
    check("d_zero", data_o, 16'h0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/conv_encoder_system.md
CONV_ENCODER_SYSTEM -- requirements
Module: conv_encoder_system

Interface
- REQ-001: Parameter FIFO_DEPTH, default 4, input byte buffer depth in entries; SHALL be a power of two, minimum 2.
- REQ-002: clk  input  1  single clock; all state changes on its rising edge.
- REQ-003: rst  input  1  reset, synchronous and active-high.
- REQ-004: dvalid_i  input  1  write strobe; data_i is sampled on every clock edge where this is high.
- REQ-005: data_i  input  8  information byte, MSB encoded first.
- REQ-006: flush_i  input  1  one-cycle tail-flush request; functional only with TAIL_FLUSH_EN.
- REQ-007: data_o  output  16  packed code word of 8 two-bit symbols.
- REQ-008: valid_o  output  1  one-cycle pulse marking data_o valid.
- REQ-009: busy_o  output  1  high while the input buffer is full.

Function
- REQ-010: The code SHALL be rate 1/2, K=3, generators G0=7 (octal), G1=5 (octal); state s[1:0], where s[1] is the most recent past bit; for input bit u, g0=u^s[1]^s[0], g1=u^s[0], then s<={u,s[1]}.
- REQ-011: Encoder state SHALL persist across byte boundaries. Only rst, or a flush under TAIL_FLUSH_EN, returns it to 00.
- REQ-012: The input buffer SHALL be a FIFO of FIFO_DEPTH bytes with registered full and empty flags.
- REQ-013: busy_o SHALL equal the full flag. A write while full SHALL be dropped with no change to buffer contents or pointers.
- REQ-014: A write and a read in the same cycle SHALL both take effect when the buffer is neither empty nor full. Pointers SHALL wrap modulo FIFO_DEPTH.
- REQ-015: The control FSM SHALL have two states, IDLE and SHIFT, with a 3-bit bit counter.
- REQ-016: In IDLE with the buffer non-empty, the FSM SHALL pop one byte into the shift register, clear the counter and go to SHIFT.
- REQ-017: In SHIFT, the FSM SHALL encode one bit per cycle, MSB first. Symbol k (k=0..7) SHALL go to data_o bits [15-2k:14-2k], with g0 in the higher bit.
- REQ-018: At counter=7 the FSM SHALL register the completed word to data_o and pulse valid_o in the following cycle. In the same cycle it SHALL pop the next byte and stay in SHIFT if the buffer is non-empty, else go to IDLE.
- REQ-019: Sustained throughput SHALL be one word per 8 cycles with no bubbles while the buffer is non-empty.
- REQ-020: For a write into an empty, idle block at edge E0: pop at E1, encode at E2..E9, valid_o high in the cycle after E9 (latency 9 cycles).
- REQ-021: data_o SHALL hold its last value between valid_o pulses.

Reset
- REQ-022: On rst high at a clock edge, the block SHALL set: FSM to IDLE, counter 0, encoder state 00, FIFO pointers 0 (empty, busy_o=0), data_o=16'h0000, valid_o=0, and clear any pending flush.
- REQ-023: Reset mid-word SHALL discard the partial word with no valid_o pulse. Any write during reset SHALL be ignored.

Configuration
- REQ-024: Macro TAIL_FLUSH_EN.
- REQ-025: When TAIL_FLUSH_EN is defined, a flush_i pulse SHALL latch a pending flush.
- REQ-026: When TAIL_FLUSH_EN is defined, a pending flush SHALL be serviced when the FSM would otherwise enter or remain IDLE with the buffer empty. Service SHALL encode an internal 0x00 byte, emit its word normally and leave state 00.
- REQ-027: When TAIL_FLUSH_EN is defined, further flush_i pulses while a flush is pending SHALL merge into it.
- REQ-028: When TAIL_FLUSH_EN is not defined, flush_i SHALL be ignored, no pad word SHALL ever be emitted, and the port SHALL remain present.

Verification
- REQ-029: Reset, then write 0x80 -> valid_o 9 cycles later, data_o=0xEC00, final state 00.
- REQ-030: Reset, then write 0xFF then 0x00 back-to-back -> words 0xDAAA then 0x7000, 8 cycles apart.
- REQ-031: Reset, then write 0xFF, then pulse flush_i -> with TAIL_FLUSH_EN: 0xDAAA then 0x7000, state 00. Without it: only 0xDAAA.
- REQ-032: Write every cycle for 20 cycles (FIFO_DEPTH=4) -> busy_o asserts, excess writes dropped, emitted words match a reference model of accepted bytes only.
- REQ-033: Assert rst at counter=4 of a word -> no valid_o pulse, data_o=0x0000. Rewriting 0x80 -> 0xEC00.
- REQ-034: Write 0x00 after reset -> data_o=0x0000 with valid_o pulse.
